// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared width, default multiplier latency and scheduler state encoding
package fp_mul_pkg;
  localparam int FP_W = 32;
  localparam int DEF_MUL_LATENCY = 50;
  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;
endpackage

// File: rtl/fp_mul_sched_if.sv
// fp_mul_sched_if: request/response/multiplier bundle; slave = scheduler, master = requesters + fp_mul
interface fp_mul_sched_if
  import fp_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [FP_W*NREQ-1:0] req_a;
  logic [FP_W*NREQ-1:0] req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [FP_W-1:0]      resp_result;
  logic                 resp_overflow;
  logic                 busy;
  logic                 mul_rst;
  logic [FP_W-1:0]      mul_a;
  logic [FP_W-1:0]      mul_b;
  logic [FP_W-1:0]      mul_c;
  logic                 mul_overflow;
  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mul_c, mul_overflow,
    output req_ready, resp_valid, resp_id, resp_result, resp_overflow, busy, mul_rst, mul_a, mul_b
  );
  modport master (
    output req_valid, req_a, req_b, resp_ready, mul_c, mul_overflow,
    input  req_ready, resp_valid, resp_id, resp_result, resp_overflow, busy, mul_rst, mul_a, mul_b
  );
endinterface

// File: rtl/fp_mul_rr_arb.sv
// fp_mul_rr_arb: combinational round-robin pick; i_req/i_ptr in, o_grant (first set bit from i_ptr upward, wrapping) and o_any out
module fp_mul_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_grant,
  output logic            o_any
);
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_pool;
  assign o_any = |i_req;
  always_comb begin
    w_hi = '0;
    for (int k = 0; k < NREQ; k++) w_hi[k] = i_req[k] && (k >= int'(i_ptr));
    w_pool = |w_hi ? w_hi : i_req;
    o_grant = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (w_pool[k]) o_grant = IDW'(k);
  end
endmodule

// File: rtl/fp_mul_sched.sv
// fp_mul_sched: round-robin sharing of one fixed-latency fp_mul; clk, rst (async active-low), bus (slave: requests, response, fp_mul drive)
module fp_mul_sched
  import fp_mul_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int CNT_W       = 6
) (
  input logic          clk,
  input logic          rst,
  fp_mul_sched_if.slave bus
);
  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [CNT_W-1:0] r_cnt;
  logic [FP_W-1:0]  r_a;
  logic [FP_W-1:0]  r_b;
  logic [FP_W-1:0]  r_res;
  logic             r_ovf;
  logic             r_valid;
  logic [IDW-1:0]   w_grant;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [FP_W-1:0]  w_a;
  logic [FP_W-1:0]  w_b;
  logic             w_any;
  fp_mul_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req  (bus.req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_any  (w_any)
  );
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant == IDW'(k)) begin
        w_a = bus.req_a[k*FP_W +: FP_W];
        w_b = bus.req_b[k*FP_W +: FP_W];
      end
    end
  end
  assign w_ptr_nxt     = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
  assign bus.req_ready = (rst && r_state == IDLE && w_any) ? NREQ'(1) << w_grant : '0;
  assign bus.busy      = r_state != IDLE;
  assign bus.mul_rst   = r_state != RUN;
  assign bus.mul_a     = r_a;
  assign bus.mul_b     = r_b;
  assign bus.resp_valid    = r_valid;
  assign bus.resp_id       = r_id;
  assign bus.resp_result   = r_res;
  assign bus.resp_overflow = r_ovf;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_a     <= w_a;
          r_b     <= w_b;
          r_id    <= w_grant;
          r_ptr   <= w_ptr_nxt;
          r_state <= START;
        end
        START: begin
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(MUL_LATENCY - 1)) begin
            r_res   <= bus.mul_c;
            r_ovf   <= bus.mul_overflow;
            r_valid <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: if (bus.resp_ready) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
